spi_slave_rx: RTL and testbench

//  Clk-domain SPI responder (receiver) for the 12-bit spi_master frame: cs low, mosi LSB first, 12 bits.
//  - Oversamples the asynchronous sclk/cs/mosi pins on clk and detects sclk edges.
//  - Reassembles the word and presents it with a one-cycle done strobe.
//  - Flags short or long frames.
//  - Replaces sclk-clocked receive logic, so downstream logic sees only clk.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync.sv | 26 ++
 rtl/spi_slave_rx.sv | 162 ++++++++++++++++
 tb/tb_spi_slave_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the clk-domain SPI receiver.
package spi_pkg;

   localparam int SPI_DATA_W = 12;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SHIFT
   } spi_rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous pin; resets to the idle bus level.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the pin through the flop chain; the last flop is the clean copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff <= {STAGES{RST_VAL}};
      end else begin
         // NOTE: non-blocking assignment so every flop samples the pre-edge value of its neighbour.
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Clk-domain SPI receiver: oversamples sclk/cs/mosi, reassembles an LSB-first
// frame of DATA_W bits, strobes done on a good frame and frame_err otherwise.
// Optional macro SPI_RX_MISO_EN adds a registered miso response driven from tx_data.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
`ifdef SPI_RX_MISO_EN
   input  logic [DATA_W-1:0] tx_data,
   output logic              miso,
`endif
   output logic [DATA_W-1:0] dout,
   output logic              done,
   output logic              frame_err,
   output logic              busy
);

   // Count must reach DATA_W+1 so an over-long frame is distinguishable from a full one.
   localparam int            CNT_W    = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

   logic sclk_s, cs_s, mosi_s;
   logic sclk_d, cs_d;
   logic sclk_fall, cs_fall, cs_rise;

   logic [SYNC_STAGES-1:0] flush_q;
   logic                   armed_q;

   spi_rx_state_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] dout_d;
   logic              done_d, err_d;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

   // Delayed copies of the synchronized pins for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end

   // Arm frame start only after cs has been seen high with the synchronizer flushed,
   // so a cs already low at reset release cannot start a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q <= '0;
         armed_q <= 1'b0;
      end else begin
         flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         armed_q <= armed_q | (flush_q[SYNC_STAGES-1] & cs_s);
      end
   end

   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d & armed_q;
   assign cs_rise   = cs_s & ~cs_d;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RX_IDLE;
      else     state_q <= state_d;
   end

   // Next-state, shift/count and strobe decisions; a coincident sclk_fall is
   // folded into the count before cs_rise judges the frame length.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      dout_d  = dout;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (cs_fall) begin
               cnt_d   = '0;
               state_d = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (sclk_fall) begin
               shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
            if (cs_rise) begin
               if (cnt_d == CNT_FULL) begin
                  dout_d = shreg_d;
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         shreg_q   <= '0;
         dout      <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         dout      <= dout_d;
         done      <= done_d;
         frame_err <= err_d;
         busy      <= (state_d == RX_SHIFT);
      end
   end

`ifdef SPI_RX_MISO_EN
   localparam int IDX_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic              miso_d;

   // Response word is latched at frame start; miso presents the bit for the current count.
   always_comb begin
      shadow_d = shadow_q;
      miso_d   = 1'b0;
      if (state_q == RX_IDLE && cs_fall) shadow_d = tx_data;
      if (state_d == RX_SHIFT && !cs_s && cnt_d < CNT_FULL)
         miso_d = shadow_d[cnt_d[IDX_W-1:0]];
   end

   // Shadow register and registered miso.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         miso     <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         miso     <= miso_d;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an in-bench SPI master (sclk = clk/22) drives the
// pins; a frame-level model predicts outputs, delayed by the synchronizer
// latency, and is compared every cycle. Literal checks pin the model.
module tb_spi_slave_rx;

   localparam int HALF = 11;
   localparam int LAT  = 3;

   logic        clk = 1'b0;
   logic        rst, sclk, cs, mosi;
   logic [11:0] dout;
   logic        done, frame_err, busy;
`ifdef SPI_RX_MISO_EN
   logic        miso;
   logic [11:0] tx_data;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;
   int n_err    = 0;
   bit busy_seen;
   logic [11:0] miso_word;

   always #5 clk = ~clk;

   spi_slave_rx dut (
      .clk(clk),
      .rst(rst),
      .sclk(sclk),
      .cs(cs),
      .mosi(mosi),
`ifdef SPI_RX_MISO_EN
      .tx_data(tx_data),
      .miso(miso),
`endif
      .dout(dout),
      .done(done),
      .frame_err(frame_err),
      .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Master: cs low, LSB-first bits with mosi updated on sclk rise; optionally ends the frame.
   task automatic send(input logic [11:0] data, input int nbits, input bit close);
      cs = 1'b0;
      tick(HALF);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         mosi = data[i % 12];
`ifdef SPI_RX_MISO_EN
         if (i < 12) miso_word[i] = miso;
`endif
         tick(HALF);
         sclk = 1'b0;
         tick(HALF);
      end
      if (close) begin
         cs   = 1'b1;
         mosi = 1'b0;
         tick(20);
      end
   endtask

   // Frame-level model: watches the pins, predicts what the outputs must be,
   // and delays the prediction by the fixed pin-to-output latency.
   typedef struct packed {
      logic        done;
      logic        err;
      logic        busy;
      logic [11:0] dout;
   } exp_t;

   exp_t        pipe [LAT];
   exp_t        cur;
   bit          m_active, m_armed, prev_cs, prev_sclk;
   int          m_cnt;
   logic [11:0] m_word, m_dout;

   always @(negedge clk) begin
      if (done) n_done++;
      if (frame_err) n_err++;
      if (busy) busy_seen = 1'b1;
      if (rst) begin
         m_active = 1'b0;
         m_armed  = 1'b0;
         m_cnt    = 0;
         m_word   = '0;
         m_dout   = '0;
         for (int i = 0; i < LAT; i++) pipe[i] = '0;
         check("rst_dout", dout, 12'h000);
         check("rst_done", done, 1'b0);
         check("rst_err", frame_err, 1'b0);
         check("rst_busy", busy, 1'b0);
      end else begin
         cur = '0;
         if (!m_active) begin
            if (m_armed && prev_cs && !cs) begin
               m_active = 1'b1;
               m_cnt    = 0;
               m_word   = '0;
            end
         end else begin
            if (prev_sclk && !sclk) begin
               if (m_cnt < 12) m_word[m_cnt] = mosi;
               if (m_cnt < 13) m_cnt++;
            end
            if (!prev_cs && cs) begin
               if (m_cnt == 12) begin
                  cur.done = 1'b1;
                  m_dout   = m_word;
               end else begin
                  cur.err = 1'b1;
               end
               m_active = 1'b0;
            end
         end
         if (cs) m_armed = 1'b1;
         cur.busy = m_active;
         cur.dout = m_dout;
         check("cyc_done", done, pipe[LAT-1].done);
         check("cyc_err", frame_err, pipe[LAT-1].err);
         check("cyc_busy", busy, pipe[LAT-1].busy);
         check("cyc_dout", dout, pipe[LAT-1].dout);
         check("cyc_strobe_excl", done & frame_err, 1'b0);
         for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = cur;
      end
      prev_cs   = cs;
      prev_sclk = sclk;
   end

   initial begin
      int d0, e0;
      rst  = 1'b1;
      cs   = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      miso_word = '0;
`ifdef SPI_RX_MISO_EN
      tx_data = '0;
`endif

      // 1: reset held while sclk toggles
      for (int i = 0; i < 30; i++) begin
         tick(1);
         sclk = ~sclk;
      end
      sclk = 1'b0;
      check("t1_dout", dout, 12'h000);
      check("t1_busy", busy, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(10);

      // 2: single good frame
      d0 = n_done; e0 = n_err; busy_seen = 1'b0;
      send(12'hA5C, 12, 1'b1);
      check("t2_dout", dout, 12'hA5C);
      check("t2_done_pulses", n_done - d0, 1);
      check("t2_err_pulses", n_err - e0, 0);
      check("t2_busy_seen", busy_seen, 1'b1);
      check("t2_busy_idle", busy, 1'b0);

      // 3: back-to-back frames
      d0 = n_done;
      send(12'h001, 12, 1'b1);
      check("t3_dout_a", dout, 12'h001);
      send(12'hFFF, 12, 1'b1);
      check("t3_dout_b", dout, 12'hFFF);
      check("t3_done_pulses", n_done - d0, 2);

      // 4: short then long frame
      d0 = n_done; e0 = n_err;
      send(12'h0AA, 7, 1'b1);
      check("t4_short_err", n_err - e0, 1);
      check("t4_short_done", n_done - d0, 0);
      check("t4_short_dout", dout, 12'hFFF);
      e0 = n_err;
      send(12'h0AA, 14, 1'b1);
      check("t4_long_err", n_err - e0, 1);
      check("t4_long_dout", dout, 12'hFFF);

      // 5: reset mid-frame, then a clean frame
      d0 = n_done; e0 = n_err;
      send(12'h3C3, 5, 1'b0);
      rst = 1'b1;
      tick(3);
      check("t5_rst_dout", dout, 12'h000);
      rst = 1'b0;
      tick(5);
      cs = 1'b1;
      tick(10);
      check("t5_no_strobe", (n_done - d0) + (n_err - e0), 0);
      send(12'h3C3, 12, 1'b1);
      check("t5_dout", dout, 12'h3C3);
      check("t5_done_pulses", n_done - d0, 1);
      check("t5_err_pulses", n_err - e0, 0);

`ifdef SPI_RX_MISO_EN
      // 6: response word on miso
      tx_data   = 12'h5A1;
      miso_word = '0;
      check("t6_miso_idle_pre", miso, 1'b0);
      send(12'h0F0, 12, 1'b1);
      check("t6_miso_word", miso_word, 12'h5A1);
      check("t6_miso_idle_post", miso, 1'b0);
      check("t6_dout", dout, 12'h0F0);
`endif

      tick(5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
